sw_event_encoder: RTL



---
 rtl/sw_event_encoder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sw_event_encoder.sv
// N-channel switch-event encoder: synchronise, debounce, edge-detect, queue, emit one event per ready cycle.
// Optional macro SW_FALL_EVENT_EN: falling stable edges also produce events (dir=1).
module sw_event_encoder #(
    parameter int N_SW            = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    localparam int IDX_W          = $clog2(N_SW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SW-1:0]  sw,
    input  logic             ready,
    output logic [IDX_W-1:0] hex,
    output logic             pulse,
    output logic             dir,
    output logic             overflow,
    output logic [N_SW-1:0]  pending
);

    localparam int CNT_W = (DEBOUNCE_CYCLES == 0) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [N_SW-1:0]  r_sync [SYNC_STAGES];
    logic [N_SW-1:0]  r_stable;
    logic [CNT_W-1:0] r_cnt [N_SW];
    logic [N_SW-1:0]  r_pending;
    logic             r_overflow;
    logic             r_pulse;
    logic [IDX_W-1:0] r_hex;

    logic [N_SW-1:0]  w_sync_out;
    logic [N_SW-1:0]  w_stable_next;
    logic [CNT_W-1:0] w_cnt_next [N_SW];
    logic [N_SW-1:0]  w_rise;
    logic [N_SW-1:0]  w_evt;
    logic [N_SW-1:0]  w_grant;
    logic [IDX_W-1:0] w_gidx;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= sw;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    // Stable flips only after the mismatch has persisted DEBOUNCE_CYCLES+1 edges.
    always_comb begin
        w_stable_next = r_stable;
        for (int i = 0; i < N_SW; i++) begin
            w_cnt_next[i] = '0;
            if (w_sync_out[i] != r_stable[i]) begin
                if (r_cnt[i] == DB_MAX) begin
                    w_stable_next[i] = w_sync_out[i];
                end else begin
                    w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable <= '0;
            for (int i = 0; i < N_SW; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_stable <= w_stable_next;
            for (int i = 0; i < N_SW; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end

    assign w_rise = ~r_stable & w_stable_next;

`ifdef SW_FALL_EVENT_EN
    logic [N_SW-1:0] w_fall;
    logic [N_SW-1:0] r_pend_dir;
    logic            r_dir;

    assign w_fall = r_stable & ~w_stable_next;
    assign w_evt  = w_rise | w_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_dir <= '0;
            r_dir      <= 1'b0;
        end else begin
            for (int i = 0; i < N_SW; i++) begin
                if (w_evt[i]) begin
                    r_pend_dir[i] <= w_fall[i];
                end
            end
            if (|w_grant) begin
                r_dir <= r_pend_dir[w_gidx];
            end
        end
    end

    assign dir = r_dir;
`else
    assign w_evt = w_rise;
    assign dir   = 1'b0;
`endif

    // Fixed priority: lowest pending index wins whenever the consumer is ready.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        for (int i = N_SW - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_gidx = IDX_W'(i);
            end
        end
        if (ready && (|r_pending)) begin
            w_grant[w_gidx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending  <= '0;
            r_overflow <= 1'b0;
            r_pulse    <= 1'b0;
            r_hex      <= '0;
        end else begin
            r_pending <= (r_pending & ~w_grant) | w_evt;
            if (|(w_evt & r_pending & ~w_grant)) begin
                r_overflow <= 1'b1;
            end
            r_pulse <= |w_grant;
            if (|w_grant) begin
                r_hex <= w_gidx;
            end
        end
    end

    assign hex      = r_hex;
    assign pulse    = r_pulse;
    assign overflow = r_overflow;
    assign pending  = r_pending;

endmodule
